alu_param: RTL and testbench

Parametrised multi-cycle integer ALU: next generation of the 8-bit sequential ALU, generalised to any operand width `W` and extended with signed mode, status flags and explicit output-valid signalling. It keeps the serial operand protocol: two operands on `inbus` in consecutive cycles, one or two result words on `outbus`. It sits behind the same control-unit style sequencer and is driven by a `BEGIN`/`END` handshake.

---
 rtl/alu_param.sv | 177 +++++++++++++++++
 tb/tb_alu_param.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_param.sv
// Parametrised multi-cycle integer ALU: serial operands on inbus, one or two
// result words on outbus, BEGIN/END handshake, signed mode, ovf/dz flags.
module alu_param #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         BEGIN,
    input  logic [1:0]   op_code,
    input  logic         sgn,
    input  logic [W-1:0] inbus,
    output logic [W-1:0] outbus,
    output logic         out_valid,
    output logic         END,
    output logic         busy,
    output logic         ovf,
    output logic         dz
);
    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {IDLE, LOADB, EXEC, FIX, OUT0, OUT1} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    state_t        state;
    op_t           op;
    logic          sgn_r;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  bm;
    logic [W:0]    p_hi;
    logic [W-1:0]  p_lo;
    logic          q1;
    logic [W+1:0]  rem;
    logic [CW-1:0] cnt;

    logic [W-1:0]  a_mag;
    logic [W-1:0]  in_mag;
    logic [W:0]    add_sum;
    logic [W:0]    sub_diff;
    logic          add_ovf;
    logic          sub_ovf;
    logic [W:0]    b_ext;
    logic [W:0]    mul_sum;
    logic [W+1:0]  rem_sh;
    logic [W+1:0]  rem_nxt;
    logic [W-1:0]  rem_fix;
    logic [W-1:0]  q_out;
    logic [W-1:0]  r_out;
    logic          div_ovf;

    always_comb begin
        a_mag    = (sgn_r && a[W-1]) ? -a : a;
        in_mag   = (sgn_r && inbus[W-1]) ? -inbus : inbus;
        add_sum  = {1'b0, a} + {1'b0, inbus};
        sub_diff = {1'b0, a} - {1'b0, inbus};
        add_ovf  = sgn_r ? ((a[W-1] == inbus[W-1]) && (add_sum[W-1] != a[W-1])) : add_sum[W];
        sub_ovf  = sgn_r ? ((a[W-1] != inbus[W-1]) && (sub_diff[W-1] != a[W-1])) : sub_diff[W];

        // One extra accumulator bit keeps Booth's +/-B and the unsigned carry exact.
        b_ext   = {sgn_r & b[W-1], b};
        mul_sum = p_hi;
        if (sgn_r) begin
            if (p_lo[0] && !q1)
                mul_sum = p_hi - b_ext;
            else if (!p_lo[0] && q1)
                mul_sum = p_hi + b_ext;
        end else if (p_lo[0]) begin
            mul_sum = p_hi + b_ext;
        end

        rem_sh  = {rem[W:0], p_lo[W-1]};
        rem_nxt = rem[W+1] ? rem_sh + {2'b00, bm} : rem_sh - {2'b00, bm};
        rem_fix = rem[W+1] ? rem[W-1:0] + bm : rem[W-1:0];

        div_ovf = sgn_r && (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
        if (b == '0) begin
            q_out = '1;
            r_out = a;
        end else begin
            q_out = (sgn_r && (a[W-1] ^ b[W-1])) ? -p_lo : p_lo;
            r_out = (sgn_r && a[W-1]) ? -rem_fix : rem_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            op        <= OP_ADD;
            sgn_r     <= 1'b0;
            a         <= '0;
            b         <= '0;
            bm        <= '0;
            p_hi      <= '0;
            p_lo      <= '0;
            q1        <= 1'b0;
            rem       <= '0;
            cnt       <= '0;
            outbus    <= '0;
            out_valid <= 1'b0;
            END       <= 1'b0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            END       <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= BEGIN;
                    if (BEGIN) begin
                        a     <= inbus;
                        op    <= op_t'(op_code);
                        sgn_r <= sgn;
                        ovf   <= 1'b0;
                        dz    <= 1'b0;
                        state <= LOADB;
                    end
                end
                LOADB: begin
                    b    <= inbus;
                    bm   <= in_mag;
                    p_hi <= '0;
                    p_lo <= (op == OP_MUL) ? a : a_mag;
                    q1   <= 1'b0;
                    rem  <= '0;
                    cnt  <= '0;
                    case (op)
                        OP_ADD: begin
                            p_hi  <= {1'b0, add_sum[W-1:0]};
                            ovf   <= add_ovf;
                            state <= OUT1;
                        end
                        OP_SUB: begin
                            p_hi  <= {1'b0, sub_diff[W-1:0]};
                            ovf   <= sub_ovf;
                            state <= OUT1;
                        end
                        OP_MUL:  state <= EXEC;
                        default: state <= (inbus == '0) ? FIX : EXEC;
                    endcase
                end
                EXEC: begin
                    if (op == OP_MUL) begin
                        p_hi <= {sgn_r & mul_sum[W], mul_sum[W:1]};
                        p_lo <= {mul_sum[0], p_lo[W-1:1]};
                        q1   <= p_lo[0];
                    end else begin
                        rem  <= rem_nxt;
                        p_lo <= {p_lo[W-2:0], ~rem_nxt[W+1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1))
                        state <= (op == OP_MUL) ? OUT0 : FIX;
                end
                FIX: begin
                    p_lo  <= q_out;
                    p_hi  <= {1'b0, r_out};
                    ovf   <= div_ovf;
                    dz    <= (b == '0);
                    state <= OUT0;
                end
                OUT0: begin
                    outbus    <= p_lo;
                    out_valid <= 1'b1;
                    state     <= OUT1;
                end
                OUT1: begin
                    outbus    <= p_hi[W-1:0];
                    out_valid <= 1'b1;
                    END       <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_param.sv
// Bench for alu_param: W=8 and W=16 instances, directed and random operations
// checked against an arithmetic reference model.
module tb_alu_param;
    logic        clk = 1'b0;
    logic        reset;
    logic        begin8, begin16;
    logic [1:0]  op_code;
    logic        sgn;
    logic [7:0]  in8;
    logic [15:0] in16;
    logic [7:0]  out8;
    logic [15:0] out16;
    logic        v8, v16, end8, end16, busy8, busy16, ovf8, ovf16, dz8, dz16;
    int          checks = 0;
    int          errors = 0;

    alu_param #(.W(8)) dut8 (
        .clk(clk), .reset(reset), .BEGIN(begin8), .op_code(op_code), .sgn(sgn),
        .inbus(in8), .outbus(out8), .out_valid(v8), .END(end8), .busy(busy8),
        .ovf(ovf8), .dz(dz8)
    );

    alu_param #(.W(16)) dut16 (
        .clk(clk), .reset(reset), .BEGIN(begin16), .op_code(op_code), .sgn(sgn),
        .inbus(in16), .outbus(out16), .out_valid(v16), .END(end16), .busy(busy16),
        .ovf(ovf16), .dz(dz16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic bg, input logic [31:0] data);
        begin8  = (w == 8)  ? bg : 1'b0;
        begin16 = (w == 16) ? bg : 1'b0;
        in8     = data[7:0];
        in16    = data[15:0];
    endtask

    // st = {out_valid, END, busy, ovf, dz}
    task automatic sample(input int w, output logic [31:0] ob, output logic [4:0] st);
        if (w == 8) begin
            ob = {24'h0, out8};
            st = {v8, end8, busy8, ovf8, dz8};
        end else begin
            ob = {16'h0, out16};
            st = {v16, end16, busy16, ovf16, dz16};
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input int w, input logic [1:0] op, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] w0, output logic [31:0] w1,
                         output logic eo, output logic ed,
                         output int first, output int lat);
        longint m, half, av, bv, r;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        av   = longint'(a) & m;
        bv   = longint'(b) & m;
        if (s && av >= half) av -= 2 * half;
        if (s && bv >= half) bv -= 2 * half;
        w0 = 0; w1 = 0; eo = 0; ed = 0; first = 2; lat = 2;
        case (op)
            2'd0, 2'd1: begin
                r  = (op == 2'd0) ? av + bv : av - bv;
                w0 = 32'(r & m);
                eo = s ? (r >= half || r < -half) : (r > m || r < 0);
            end
            2'd2: begin
                r     = av * bv;
                w0    = 32'(r & m);
                w1    = 32'((r >>> w) & m);
                first = w + 2;
                lat   = w + 3;
            end
            default: begin
                first = w + 3;
                lat   = w + 4;
                if (bv == 0) begin
                    w0 = 32'(m); w1 = 32'(longint'(a) & m); ed = 1;
                    first = 3; lat = 4;
                end else if (s && av == -half && bv == -1) begin
                    w0 = 32'(half); w1 = 0; eo = 1;
                end else begin
                    w0 = 32'((av / bv) & m);
                    w1 = 32'((av % bv) & m);
                end
            end
        endcase
    endtask

    // Called at a negedge; returns at the negedge of the END cycle.
    task automatic run_op(input int w, input logic [1:0] op, input logic s,
                          input logic [31:0] a, input logic [31:0] b, input int pulse,
                          output logic [31:0] last, output logic [1:0] fl);
        logic [31:0] w0, w1, ob;
        logic        eo, ed;
        logic [4:0]  st;
        int          first, lat;
        string       tag;
        model(w, op, s, a, b, w0, w1, eo, ed, first, lat);
        tag = $sformatf("w%0d op%0d s%0d a%0h b%0h", w, op, s, a, b);
        op_code = op;
        sgn     = s;
        drive(w, 1'b1, a);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, b);
        sample(w, ob, st);
        chk({tag, " busy"}, {31'b0, st[2]}, 32'd1);
        for (int e = 1; e <= lat; e++) begin
            @(posedge clk);
            @(negedge clk);
            drive(w, (e == pulse), $urandom);
            sample(w, ob, st);
            if (e == first) begin
                chk({tag, " word0"}, ob, w0);
                chk({tag, " stat0"}, {27'b0, st}, {27'b0, 1'b1, (first == lat), 1'b1, eo, ed});
            end else if (e == lat) begin
                chk({tag, " word1"}, ob, w1);
                chk({tag, " stat1"}, {27'b0, st}, {27'b0, 3'b111, eo, ed});
            end else begin
                chk({tag, " quiet"}, {29'b0, st[4:2]}, 32'd1);
            end
        end
        last = (first == lat) ? w0 : w1;
        fl   = {eo, ed};
    endtask

    task automatic idle_chk(input int w, input logic [31:0] last, input logic [1:0] fl);
        logic [31:0] ob;
        logic [4:0]  st;
        @(posedge clk);
        @(negedge clk);
        sample(w, ob, st);
        chk($sformatf("w%0d idle outbus", w), ob, last);
        chk($sformatf("w%0d idle stat", w), {27'b0, st}, {27'b0, 3'b000, fl});
    endtask

    task automatic op_idle(input int w, input logic [1:0] op, input logic s,
                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] last;
        logic [1:0]  fl;
        run_op(w, op, s, a, b, 0, last, fl);
        idle_chk(w, last, fl);
    endtask

    initial begin
        logic [31:0] ob, last, a, b, mask;
        logic [4:0]  st;
        logic [1:0]  fl;
        logic        seen;
        int          w;

        reset = 1'b0;
        op_code = 2'd0;
        sgn = 1'b0;
        drive(8, 1'b0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        sample(8, ob, st);
        chk("reset w8 outbus", ob, 0);
        chk("reset w8 stat", {27'b0, st}, 0);
        sample(16, ob, st);
        chk("reset w16 outbus", ob, 0);
        chk("reset w16 stat", {27'b0, st}, 0);
        reset = 1'b1;

        op_idle(8, 2'd0, 1'b0, 56, 89);
        op_idle(8, 2'd0, 1'b1, 56, 89);
        op_idle(8, 2'd1, 1'b0, 56, 89);
        op_idle(8, 2'd2, 1'b0, 56, 89);
        op_idle(8, 2'd2, 1'b1, 8'hFD, 5);
        op_idle(8, 2'd2, 1'b1, 8'h80, 8'h80);
        op_idle(8, 2'd2, 1'b0, 8'hFF, 8'hFF);
        op_idle(8, 2'd3, 1'b0, 200, 7);
        op_idle(8, 2'd3, 1'b1, 8'hF9, 2);
        op_idle(8, 2'd3, 1'b1, 7, 8'hFE);
        op_idle(8, 2'd3, 1'b0, 5, 0);
        op_idle(8, 2'd3, 1'b1, 8'h80, 8'hFF);
        op_idle(8, 2'd3, 1'b0, 8'hFF, 1);
        op_idle(16, 2'd2, 1'b0, 1000, 300);
        op_idle(16, 2'd3, 1'b1, 16'h8000, 3);

        // BEGIN pulsed mid-operation must not restart the unit
        run_op(8, 2'd2, 1'b1, 8'h9C, 8'h37, 3, last, fl);
        idle_chk(8, last, fl);

        // back-to-back: BEGIN already high in the END cycle
        run_op(8, 2'd0, 1'b0, 200, 100, 0, last, fl);
        run_op(8, 2'd1, 1'b1, 8'h80, 1, 0, last, fl);
        idle_chk(8, last, fl);

        // reset at edge 5 of a MUL aborts it; BEGIN on that edge is ignored
        op_code = 2'd2;
        sgn = 1'b0;
        drive(8, 1'b1, 77);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b0, 33);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b0;
        op_code = 2'd0;
        drive(8, 1'b1, 5);
        @(posedge clk);
        @(negedge clk);
        sample(8, ob, st);
        chk("rst_mid outbus", ob, 0);
        chk("rst_mid stat", {27'b0, st}, 0);
        reset = 1'b1;
        drive(8, 1'b0, 0);
        seen = 1'b0;
        repeat (14) begin
            @(posedge clk);
            @(negedge clk);
            sample(8, ob, st);
            if (st[4] || st[3] || st[2]) seen = 1'b1;
        end
        chk("rst_mid no activity", {31'b0, seen}, 0);
        op_idle(8, 2'd0, 1'b0, 3, 4);

        for (int i = 0; i < 28; i++) begin
            w    = (i % 4 == 3) ? 16 : 8;
            mask = (w == 8) ? 32'hFF : 32'hFFFF;
            a    = $urandom & mask;
            b    = $urandom & mask;
            if ($urandom_range(0, 7) == 0) b = 0;
            run_op(w, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, b, 0, last, fl);
            if (i == 27 || $urandom_range(0, 1) == 1) idle_chk(w, last, fl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
